// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES <-> SPI byte sequencer.
package aes_spi_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned AES_BLOCK_BYTES = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StShift   = 3'd2,
    StCapture = 3'd3,
    StGap     = 3'd4,
    StDone    = 3'd5
  } seq_state_t;

  // States during which a block transfer is in progress (busy, abortable).
  function automatic logic in_block(input seq_state_t s);
    return (s == StLoad) || (s == StShift) || (s == StCapture) || (s == StGap);
  endfunction

endpackage

// File: rtl/aes_spi_sequencer.sv
// Moves one block between the AES datapath and the SPI master, one byte per
// chip-select frame, MSB byte first. All outputs are registered.
module aes_spi_sequencer
  import aes_spi_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = AES_BLOCK_BYTES,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                        sclk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [BYTE_W*NUM_BYTES-1:0] data_in,
  output logic [BYTE_W*NUM_BYTES-1:0] data_out,
  output logic                        busy,
  output logic                        done,
  output logic                        CS,
  output logic [BYTE_W-1:0]           MDS,
  input  logic [BYTE_W-1:0]           MDO
);

  localparam int unsigned ByteW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned GapW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [ByteW-1:0] ByteLast = ByteW'(NUM_BYTES - 1);
  // Unreachable when GAP_CYCLES is 0 (the GAP state is never entered).
  localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);

  seq_state_t state_q, state_d;

  logic [NUM_BYTES-1:0][BYTE_W-1:0] tx_buf_q, tx_buf_d;
  logic [NUM_BYTES-1:0][BYTE_W-1:0] rx_buf_q, rx_buf_d;
  logic [ByteW-1:0]                 byte_cnt_q, byte_cnt_d;
  logic [2:0]                       bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]                  gap_cnt_q, gap_cnt_d;

  logic [BYTE_W-1:0]           mds_q, mds_d;
  logic                        cs_q, cs_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [BYTE_W*NUM_BYTES-1:0] data_out_q, data_out_d;

  logic last_byte;
  logic advance;

  // Sequencing: state, counters and byte buffers.
  always_comb begin
    state_d    = state_q;
    tx_buf_d   = tx_buf_q;
    rx_buf_d   = rx_buf_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    advance    = 1'b0;
    last_byte  = (byte_cnt_q == ByteLast);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_buf_d   = data_in;
          byte_cnt_d = '0;
          state_d    = StLoad;
        end
      end
      StLoad: begin
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        if (bit_cnt_q == 3'd7) begin
          state_d = StCapture;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      StCapture: begin
        // Byte 0 of the transfer lands in the most significant byte lane.
        rx_buf_d[ByteLast - byte_cnt_q] = MDO;
        if (GAP_CYCLES > 0) begin
          gap_cnt_d = '0;
          state_d   = StGap;
        end else begin
          advance = 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          advance = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StDone: begin
        // A start seen here is deliberately dropped.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Next-byte decision, shared by CAPTURE (no gap) and the last GAP cycle.
    if (advance) begin
      if (last_byte) begin
        state_d = StDone;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        state_d    = StLoad;
      end
    end

    if (abort && in_block(state_q)) begin
      state_d = StIdle;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_comb begin
    mds_d      = mds_q;
    data_out_d = data_out_q;
    cs_d       = (state_d != StShift);
    busy_d     = in_block(state_d);
    done_d     = (state_d == StDone);
    // MDS is loaded on entry to LOAD and then held through SHIFT.
    if (state_d == StLoad) begin
      mds_d = tx_buf_d[ByteLast - byte_cnt_d];
    end
    // rx_buf_d already carries the final byte when CAPTURE goes straight to DONE.
    if (state_d == StDone) begin
      data_out_d = rx_buf_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_buf_q   <= '0;
      rx_buf_q   <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      mds_q      <= '0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_buf_q   <= tx_buf_d;
      rx_buf_q   <= rx_buf_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      mds_q      <= mds_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign MDS      = mds_q;
  assign CS       = cs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_spi_sequencer.sv
// Self-checking bench: three sequencer instances (defaults, no gap, one byte)
// against a cycle-timing reference model and a loopback SPI slave.
module tb_aes_spi_sequencer;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic         reset = 1'b0;
  logic         abort = 1'b0;
  logic         start_v [3] = '{1'b0, 1'b0, 1'b0};
  logic [127:0] data_in = '0;
  logic         cs_v   [3];
  logic         busy_v [3];
  logic         done_v [3];
  logic [7:0]   mds_v  [3];
  logic [7:0]   mdo_v  [3] = '{8'h00, 8'h00, 8'h00};
  logic [127:0] dout0, dout1;
  logic [7:0]   dout2;

  int tests = 0;
  int fails = 0;
  int nb [3] = '{16, 16, 1};
  int gp [3] = '{1, 0, 1};
  int lowcnt [3] = '{0, 0, 0};
  logic [127:0] last_out [3] = '{128'd0, 128'd0, 128'd0};

  aes_spi_sequencer dut0 (
    .sclk(sclk), .reset(reset), .start(start_v[0]), .abort(abort), .data_in(data_in),
    .data_out(dout0), .busy(busy_v[0]), .done(done_v[0]), .CS(cs_v[0]), .MDS(mds_v[0]),
    .MDO(mdo_v[0])
  );

  aes_spi_sequencer #(.GAP_CYCLES(0)) dut1 (
    .sclk(sclk), .reset(reset), .start(start_v[1]), .abort(abort), .data_in(data_in),
    .data_out(dout1), .busy(busy_v[1]), .done(done_v[1]), .CS(cs_v[1]), .MDS(mds_v[1]),
    .MDO(mdo_v[1])
  );

  aes_spi_sequencer #(.NUM_BYTES(1)) dut2 (
    .sclk(sclk), .reset(reset), .start(start_v[2]), .abort(abort), .data_in(data_in[7:0]),
    .data_out(dout2), .busy(busy_v[2]), .done(done_v[2]), .CS(cs_v[2]), .MDS(mds_v[2]),
    .MDO(mdo_v[2])
  );

  // Loopback slave: junk on MDO while shifting, MDS^FF after the 8th low-CS edge.
  always @(posedge sclk) begin
    for (int i = 0; i < 3; i++) begin
      if (!cs_v[i]) begin
        if (lowcnt[i] == 7) begin
          mdo_v[i]  <= mds_v[i] ^ 8'hFF;
          lowcnt[i] <= 0;
        end else begin
          mdo_v[i]  <= 8'($urandom());
          lowcnt[i] <= lowcnt[i] + 1;
        end
      end else begin
        lowcnt[i] <= 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Byte k in transmit order (k=0 is the most significant byte of an n-byte block).
  function automatic logic [7:0] byte_of(input logic [127:0] b, input int n, input int k);
    logic [127:0] t;
    t = b >> (8 * (n - 1 - k));
    return t[7:0];
  endfunction

  task automatic observe(input int sel, output logic cs, output logic busy, output logic done,
                         output logic [7:0] mds, output logic [127:0] dout);
    cs   = cs_v[sel];
    busy = busy_v[sel];
    done = done_v[sel];
    mds  = mds_v[sel];
    dout = (sel == 0) ? dout0 : (sel == 1) ? dout1 : {120'd0, dout2};
  endtask

  task automatic idle(input int sel, input int cycles);
    logic o_cs, o_busy, o_done;
    logic [7:0] o_mds;
    logic [127:0] o_dout;
    for (int i = 0; i < cycles; i++) begin
      observe(sel, o_cs, o_busy, o_done, o_mds, o_dout);
      check($sformatf("d%0d idle cs", sel), 128'(o_cs), 128'd1);
      check($sformatf("d%0d idle busy", sel), 128'(o_busy), 128'd0);
      check($sformatf("d%0d idle done", sel), 128'(o_done), 128'd0);
      check($sformatf("d%0d idle dout", sel), o_dout, last_out[sel]);
      step();
    end
  endtask

  // Starts a block at cycle 0 and checks every following cycle against the
  // timing rules. cut_at>0 applies abort (or reset) during that cycle.
  task automatic run_block(input int sel, input logic [127:0] blk, input int cut_at,
                           input bit cut_rst, input bit noise);
    int n, p, total, last_c, dones, ph;
    logic [127:0] rx;
    logic o_cs, o_busy, o_done;
    logic [7:0] o_mds;
    logic [127:0] o_dout;
    n      = nb[sel];
    p      = 10 + gp[sel];
    total  = n * p + 1;
    dones  = 0;
    rx     = '0;
    for (int k = 0; k < n; k++) rx = (rx << 8) | 128'(byte_of(blk, n, k) ^ 8'hFF);
    last_c = (cut_at > 0) ? cut_at + 1 : total + 1;

    data_in      = blk;
    start_v[sel] = 1'b1;
    step();
    start_v[sel] = 1'b0;

    for (int c = 1; c <= last_c; c++) begin
      observe(sel, o_cs, o_busy, o_done, o_mds, o_dout);
      if (o_done) dones++;
      if (cut_at > 0 && c > cut_at) begin
        check($sformatf("d%0d c%0d cut cs", sel, c), 128'(o_cs), 128'd1);
        check($sformatf("d%0d c%0d cut busy", sel, c), 128'(o_busy), 128'd0);
        check($sformatf("d%0d c%0d cut done", sel, c), 128'(o_done), 128'd0);
        check($sformatf("d%0d c%0d cut dout", sel, c), o_dout, last_out[sel]);
        if (cut_rst) check($sformatf("d%0d c%0d rst mds", sel, c), 128'(o_mds), 128'd0);
      end else if (c <= n * p) begin
        ph = (c - 1) % p;
        check($sformatf("d%0d c%0d cs", sel, c), 128'(o_cs),
              128'((ph >= 1 && ph <= 8) ? 0 : 1));
        check($sformatf("d%0d c%0d busy", sel, c), 128'(o_busy), 128'd1);
        check($sformatf("d%0d c%0d done", sel, c), 128'(o_done), 128'd0);
        check($sformatf("d%0d c%0d mds", sel, c), 128'(o_mds),
              128'(byte_of(blk, n, (c - 1) / p)));
        check($sformatf("d%0d c%0d dout", sel, c), o_dout, last_out[sel]);
      end else begin
        check($sformatf("d%0d c%0d cs", sel, c), 128'(o_cs), 128'd1);
        check($sformatf("d%0d c%0d busy", sel, c), 128'(o_busy), 128'd0);
        check($sformatf("d%0d c%0d done", sel, c), 128'(o_done), 128'(c == total));
        check($sformatf("d%0d c%0d dout", sel, c), o_dout, rx);
      end
      if (noise && (c == 5 || c == total)) begin
        start_v[sel] = 1'b1;
        data_in      = rand128();
      end
      if (c == cut_at) begin
        if (cut_rst) begin
          reset = 1'b1;
          for (int i = 0; i < 3; i++) last_out[i] = '0;
        end else begin
          abort = 1'b1;
        end
      end
      step();
      start_v[sel] = 1'b0;
      abort        = 1'b0;
      reset        = 1'b0;
    end
    check($sformatf("d%0d done count", sel), 128'(dones), 128'((cut_at > 0) ? 0 : 1));
    if (cut_at <= 0) last_out[sel] = rx;
  endtask

  initial begin
    logic o_cs, o_busy, o_done;
    logic [7:0] o_mds;
    logic [127:0] o_dout;
    int sel, cut;

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      observe(i, o_cs, o_busy, o_done, o_mds, o_dout);
      check($sformatf("d%0d reset cs", i), 128'(o_cs), 128'd1);
      check($sformatf("d%0d reset mds", i), 128'(o_mds), 128'd0);
      check($sformatf("d%0d reset busy", i), 128'(o_busy), 128'd0);
      check($sformatf("d%0d reset done", i), 128'(o_done), 128'd0);
      check($sformatf("d%0d reset dout", i), o_dout, 128'd0);
    end

    // Nominal block on defaults and on the gapless variant.
    run_block(0, 128'h00112233445566778899AABBCCDDEEFF, 0, 1'b0, 1'b0);
    check("nominal dout", dout0, 128'hFFEEDDCCBBAA99887766554433221100);
    run_block(1, 128'h00112233445566778899AABBCCDDEEFF, 0, 1'b0, 1'b0);
    check("nogap dout", dout1, 128'hFFEEDDCCBBAA99887766554433221100);

    // Abort during SHIFT of byte 4, then restart at cycle 52.
    run_block(0, rand128(), 50, 1'b0, 1'b0);
    run_block(0, rand128(), 0, 1'b0, 1'b0);

    // Starts at cycle 5 and in DONE are ignored.
    run_block(0, rand128(), 0, 1'b0, 1'b1);

    // Reset at cycle 30, restart at cycle 40.
    run_block(0, rand128(), 30, 1'b1, 1'b0);
    idle(0, 8);
    run_block(0, rand128(), 0, 1'b0, 1'b0);

    // Single-byte block.
    run_block(2, 128'hA5, 0, 1'b0, 1'b0);
    check("one byte dout", {120'd0, dout2}, 128'h5A);

    // Randomized blocks with occasional aborts on all three instances.
    for (int r = 0; r < 9; r++) begin
      sel = r % 3;
      cut = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nb[sel] * (10 + gp[sel]))) : 0;
      run_block(sel, rand128(), cut, 1'b0, 1'b0);
      idle(sel, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
